// File: rtl/data_bus_responder.sv
// Data-port responder for the stack core: memory-mapped I/O window (debounced inputs,
// seven-segment registers, timer, sticky range-error status) plus the stack RAM.
module data_bus_responder #(
    parameter logic [15:0] STACK_BEGIN     = 16'h0010,
    parameter int          RAM_DEPTH       = 256,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] TICK_DIV        = 16'd50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_ram,
    input  logic        wren_ram,
    input  logic [15:0] data_ram,
    output logic [15:0] q_ram,
    input  logic [9:0]  SW,
    input  logic [1:0]  KEY,
    output logic [15:0] SEG1,
    output logic [15:0] SEG2,
    output logic        range_err
);

    localparam int          AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int          NUM_IN   = 12;
    localparam logic [16:0] RAM_END  = {1'b0, STACK_BEGIN} + 17'(RAM_DEPTH);

    localparam logic [15:0] ADDR_INPUT  = 16'h0000;
    localparam logic [15:0] ADDR_SEG1   = 16'h0001;
    localparam logic [15:0] ADDR_SEG2   = 16'h0002;
    localparam logic [15:0] ADDR_TIMER  = 16'h0003;
    localparam logic [15:0] ADDR_STATUS = 16'h0004;

    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] sync_a;
    logic [NUM_IN-1:0] sync_b;
    logic [NUM_IN-1:0] debounced;
    logic [15:0]       db_count [NUM_IN];

    logic [15:0] prescaler;
    logic [15:0] timer;
    logic        status_err;

    logic          in_ram;
    logic          out_of_range;
    logic [AW-1:0] ram_idx;
    logic [15:0]   read_data;
    logic          status_clear;

    logic [15:0] mem [RAM_DEPTH];

    assign raw_in    = {SW, KEY};
    assign range_err = status_err;

    // Each bit must disagree with its debounced value for DEBOUNCE_CYCLES
    // consecutive synchronized samples before the debounced value follows it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            debounced <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                db_count[i] <= '0;
            end
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync_b[i] == debounced[i]) begin
                    db_count[i] <= '0;
                end else if (db_count[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    debounced[i] <= sync_b[i];
                    db_count[i]  <= '0;
                end else begin
                    db_count[i] <= db_count[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            timer     <= '0;
        end else if (prescaler == TICK_DIV - 16'd1) begin
            prescaler <= '0;
            timer     <= timer + 16'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    always_comb begin
        in_ram       = (address_ram >= STACK_BEGIN) && ({1'b0, address_ram} < RAM_END);
        out_of_range = ({1'b0, address_ram} >= RAM_END);
        ram_idx      = AW'(address_ram - STACK_BEGIN);
        status_clear = wren_ram && (address_ram == ADDR_STATUS) && data_ram[0];
        read_data    = '0;
        if (in_ram) begin
            read_data = mem[ram_idx];
        end else begin
            case (address_ram)
                ADDR_INPUT:  read_data = {4'b0000, debounced};
                ADDR_SEG1:   read_data = SEG1;
                ADDR_SEG2:   read_data = SEG2;
                ADDR_TIMER:  read_data = timer;
                ADDR_STATUS: read_data = {15'd0, status_err};
                default:     read_data = '0;
            endcase
        end
    end

    // Reads sample the pre-edge contents, so a same-cycle write is seen one read later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_ram      <= '0;
            SEG1       <= '0;
            SEG2       <= '0;
            status_err <= 1'b0;
        end else begin
            q_ram <= read_data;
            if (wren_ram && address_ram == ADDR_SEG1) begin
                SEG1 <= data_ram;
            end
            if (wren_ram && address_ram == ADDR_SEG2) begin
                SEG2 <= data_ram;
            end
            if (out_of_range) begin
                status_err <= 1'b1;
            end else if (status_clear) begin
                status_err <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && wren_ram && in_ram) begin
            mem[ram_idx] <= data_ram;
        end
    end

endmodule
